// File: rtl/tile_dict_pkg.sv
// Shared types for the tile dictionary lookup: entry layout, FSM states, default widths.
package tile_dict_pkg;

  localparam int DEF_REPL_W = 10;

  typedef struct packed {
    logic                  valid;
    logic [15:0]           tag;
    logic [DEF_REPL_W-1:0] repl;
  } dict_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    RESP  = 2'd2,
    CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/tile_dict_if.sv
// Hash input, dictionary config and lookup-result bundle between the host/consumers and tile_dict_lookup.
interface tile_dict_if
  import tile_dict_pkg::*;
#(
  parameter int IDX_BITS  = 8,
  parameter int REPL_W    = DEF_REPL_W,
  parameter int MAX_PROBE = 4
);
  localparam int PROBE_W = $clog2(MAX_PROBE + 1);

  logic                  hash_valid;
  logic [15:0]           hash_in;
  logic                  hash_ovf;
  logic                  cfg_we;
  logic [IDX_BITS-1:0]   cfg_addr;
  logic [16+REPL_W:0]    cfg_wdata;
  logic                  cfg_clear;
  logic                  cfg_busy;
  logic                  result_valid;
  logic                  result_ready;
  logic                  result_hit;
  logic [REPL_W-1:0]     result_repl;
  logic [15:0]           result_hash;
  logic [PROBE_W-1:0]    result_probes;

  modport master (
    output hash_valid, hash_in, cfg_we, cfg_addr, cfg_wdata, cfg_clear, result_ready,
    input  hash_ovf, cfg_busy, result_valid, result_hit, result_repl, result_hash, result_probes
  );

  modport slave (
    input  hash_valid, hash_in, cfg_we, cfg_addr, cfg_wdata, cfg_clear, result_ready,
    output hash_ovf, cfg_busy, result_valid, result_hit, result_repl, result_hash, result_probes
  );

endinterface

// File: rtl/tile_dict_ram.sv
// Simple dual-port dictionary RAM: one write port, one synchronous read-first read port, no reset.
module tile_dict_ram
  import tile_dict_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int DATA_W   = $bits(dict_entry_t)
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [IDX_BITS-1:0] i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [IDX_BITS-1:0] i_raddr,
  output logic [DATA_W-1:0]   o_rdata
);
  logic [DATA_W-1:0] r_mem [2**IDX_BITS];
  logic [DATA_W-1:0] r_rdata;

  // Read sees the array before this cycle's write lands.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tile_dict_lookup.sv
// Buffers tile hashes in a 2-deep FIFO and linearly probes an open-addressed dictionary for a replacement ID.
module tile_dict_lookup
  import tile_dict_pkg::*;
#(
  parameter int IDX_BITS  = 8,
  parameter int REPL_W    = DEF_REPL_W,
  parameter int MAX_PROBE = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  tile_dict_if.slave bus
);
  localparam int PW = $clog2(MAX_PROBE + 1);
  localparam int EW = 17 + REPL_W;

  state_t              r_state, w_next;
  logic                r_boot, r_clr_pend, r_ovf;
  logic [15:0]         r_fifo [2];
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_count;
  logic [IDX_BITS-1:0] r_sweep, r_addr;
  logic [15:0]         r_hash;
  logic [PW-1:0]       r_cnt;
  logic                r_res_hit;
  logic [REPL_W-1:0]   r_res_repl;
  logic [15:0]         r_res_hash;
  logic [PW-1:0]       r_res_probes;

  logic                w_busy, w_res_valid, w_pop, w_push, w_start_clear, w_clr_req;
  logic                w_hit, w_decided, w_we;
  logic [15:0]         w_head;
  logic [EW-1:0]       w_rdata, w_wdata;
  logic [IDX_BITS-1:0] w_raddr, w_waddr;

  assign w_clr_req = r_boot | r_clr_pend;
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_hit     = w_rdata[EW-1] && (w_rdata[EW-2 -: 16] == r_hash);
  assign w_decided = w_hit || !w_rdata[EW-1] || (r_cnt == PW'(MAX_PROBE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_clr_req) w_next = CLEAR;
               else if (r_count != 2'd0) w_next = PROBE;
      PROBE:   if (w_decided) w_next = RESP;
      RESP:    if (bus.result_ready) w_next = IDLE;
      CLEAR:   if (r_sweep == '1) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy        = (r_state == CLEAR);
    w_res_valid   = (r_state == RESP);
    w_start_clear = (r_state == IDLE) && w_clr_req;
    w_pop         = (r_state == IDLE) && !w_clr_req && (r_count != 2'd0);
  end

  // A full FIFO still accepts a push when the same cycle pops.
  assign w_push = bus.hash_valid && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= bus.hash_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (bus.hash_valid && !w_push) r_ovf <= 1'b1;
    end
  end

  // Reset leaves RAM contents undefined, so it requests the first sweep itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_boot     <= 1'b1;
      r_clr_pend <= 1'b0;
      r_sweep    <= '0;
    end else begin
      if (w_start_clear) r_boot <= 1'b0;
      r_clr_pend <= bus.cfg_clear | (r_clr_pend & ~w_start_clear);
      if (w_start_clear) r_sweep <= '0;
      else if (w_busy)   r_sweep <= r_sweep + 1'b1;
    end
  end

  assign w_raddr = w_pop ? w_head[IDX_BITS-1:0] : r_addr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_hash       <= '0;
      r_cnt        <= '0;
      r_res_hit    <= 1'b0;
      r_res_repl   <= '0;
      r_res_hash   <= '0;
      r_res_probes <= '0;
    end else if (w_pop) begin
      r_addr <= w_head[IDX_BITS-1:0];
      r_hash <= w_head;
      r_cnt  <= PW'(1);
    end else if (r_state == PROBE) begin
      if (w_decided) begin
        r_res_hit    <= w_hit;
        r_res_repl   <= w_hit ? w_rdata[REPL_W-1:0] : '0;
        r_res_hash   <= r_hash;
        r_res_probes <= r_cnt;
      end else begin
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // The clear sweep owns the write port; host writes are dropped meanwhile.
  assign w_we    = w_busy | bus.cfg_we;
  assign w_waddr = w_busy ? r_sweep : bus.cfg_addr;
  assign w_wdata = w_busy ? '0 : bus.cfg_wdata;

  tile_dict_ram #(.IDX_BITS(IDX_BITS), .DATA_W(EW)) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign bus.hash_ovf      = r_ovf;
  assign bus.cfg_busy      = w_busy;
  assign bus.result_valid  = w_res_valid;
  assign bus.result_hit    = r_res_hit;
  assign bus.result_repl   = r_res_repl;
  assign bus.result_hash   = r_res_hash;
  assign bus.result_probes = r_res_probes;

endmodule

// File: doc/tile_dict_lookup.md
# tile_dict_lookup

Downstream consumer of the tile CRC-16 hash stage. Takes each 16-bit tile hash and probes an on-chip open-addressed dictionary to decide whether the tile has a translated replacement. Returns hit/miss plus the replacement tile ID to the tile-substitution stage. The upstream hash stage has no backpressure, so this block buffers hashes internally. Dictionary contents are loaded by the host through a config write port.

## Interface
- IDX_BITS, 8: log2 of dictionary entries (2^IDX_BITS slots)
- REPL_W, 10: replacement tile ID width
- MAX_PROBE, 4: maximum linear probes per lookup, legal range 1..2^IDX_BITS
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- hash_valid  in  1  one-cycle pulse, hash present; no ready is returned
- hash_in  in  16  CRC-16 tile hash
- hash_ovf  out  1  sticky: a hash_valid arrived while the input FIFO was full; cleared only by reset
- cfg_we  in  1  dictionary write strobe
- cfg_addr  in  IDX_BITS  slot address
- cfg_wdata  in  17+REPL_W  {valid, tag[15:0], repl[REPL_W-1:0]}
- cfg_clear  in  1  pulse: invalidate all slots
- cfg_busy  out  1  clear sweep in progress
- result_valid  out  1  lookup result available
- result_ready  in  1  consumer accepts result
- result_hit  out  1  tag match found
- result_repl  out  REPL_W  replacement ID when hit, 0 on miss
- result_hash  out  16  hash the result belongs to
- result_probes  out  $clog2(MAX_PROBE+1)  slots read for this lookup

## Operation
- Input FIFO depth 2. hash_valid pushes hash_in.
  - If full: value dropped, hash_ovf set.
  - A push and a pop in the same cycle while full is accepted.
- Home slot = hash[IDX_BITS-1:0]. Probe i reads slot (home + i) mod 2^IDX_BITS, so the probe sequence wraps from the top slot to 0.
- A probe ends the lookup on:
  - entry.valid && entry.tag == hash: hit, result_repl = entry.repl
  - !entry.valid: miss
  - MAX_PROBE slots read without either: miss
- FSM states:
  - CLEAR: sweep counter writes valid=0 to every slot, one slot per cycle, 2^IDX_BITS cycles; cfg_busy=1; go to IDLE after the last slot.
  - IDLE: if a clear is pending, go to CLEAR. Otherwise, if the FIFO is non-empty, pop it, issue a read of the home slot, and go to PROBE.
  - PROBE: compare the returned entry. If the lookup is decided, register the result and go to RESP. Otherwise issue the next slot read and stay in PROBE.
  - RESP: result_* held stable while result_valid=1; on result_ready, go to IDLE.
- cfg_clear is latched as pending in any state and is serviced only from IDLE. A lookup in progress completes against old contents.
- cfg_we is ignored while cfg_busy=1. Otherwise it writes in any state.
- The RAM is read-first: a write and a read to the same slot in the same cycle returns the old data.
- Reset: all outputs 0, FIFO empty, pending clear cleared. The FSM then enters CLEAR automatically because RAM contents are not reset.
- Reset asserted mid-lookup or mid-clear aborts immediately; the post-reset clear sweep restarts from slot 0.

## Timing
- Pop at cycle T, lookup decided after k probes: result_valid=1 from T+1+k. Hit in the home slot gives T+2.
- Minimum spacing between result_valid assertions is 3 cycles: RESP, IDLE, then at least one PROBE.
- Sync RAM read latency is 1 cycle: address issued in cycle t, data compared in t+1.
- cfg_busy rises the cycle after reset deassertion, or the cycle after IDLE sees a pending clear. It stays high exactly 2^IDX_BITS cycles.

## Structure
- Shared package tile_dict_pkg holds:
  - dict_entry_t packed struct {valid, tag[15:0], repl}
  - state enum {IDLE, PROBE, RESP, CLEAR}
  - REPL_W default constant
- Sub-module tile_dict_ram: simple dual-port (1W/1R), synchronous read-first, no reset, width $bits(dict_entry_t), depth 2^IDX_BITS.
- The 2-entry FIFO is inline.

## Test plan
Defaults are IDX_BITS=8, REPL_W=10, MAX_PROBE=4.
- Reset release → cfg_busy high for exactly 256 cycles. Then hash 0x1234 gives miss, probes=1, result_valid at T+2.
- Write slot 0x34={1,0x1234,0x155}; hash 0x1234 → hit, repl=0x155, probes=1, result_valid at T+2.
- Slot 0x34 tag 0xAA34, slot 0x35 {1,0x1234,0x0A0} → hit, repl=0x0A0, probes=2, at T+3.
- Wrap: slot 0xFF tag 0x11FF, slot 0x00 {1,0x22FF,0x3FF}; hash 0x22FF → hit, repl=0x3FF, probes=2.
- Chain exhaustion: slots 0x34..0x37 valid, non-matching tags; hash 0x9934 → miss, probes=4, at T+5.
- Backpressure:
  - Setup: result_ready=0 for 20 cycles; hash pulses 0x0001, 0x0002, 0x0003, 0x0004.
  - First lookup is held in RESP; 0x0002 and 0x0003 are buffered; 0x0004 is dropped and hash_ovf=1.
  - Once result_ready rises, results for 0x0001, 0x0002, 0x0003 are delivered in order, each stable until accepted.
- cfg_clear pulsed during a PROBE that will hit → that hit is still returned, then cfg_busy runs 256 cycles, then the same hash misses.
